tmds_dc_balance: RTL and testbench

//  Second half of the TMDS channel encoder. Consumes the 9-bit transition-minimised word (qm) and produces
//  the 10-bit DC-balanced TMDS symbol, using a running disparity tally (DVI 1.0 encoding algorithm).

---
 rtl/tmds_dc_balance.sv | 115 +++++++++++
 tb/tb_tmds_dc_balance.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tmds_dc_balance.sv
// TMDS DC-balance stage: turns the 9-bit transition-minimised word into a 10-bit symbol
// using a running disparity tally, and emits control tokens during blanking.
module tmds_dc_balance #(
    parameter int unsigned TALLY_WIDTH = 5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [8:0]                    qm_in,
    input  logic                          ve_in,
    input  logic [1:0]                    ctrl_in,
    output logic [9:0]                    tmds_out,
    output logic signed [TALLY_WIDTH-1:0] tally_out
);

    localparam int unsigned QM_W   = 9;
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned DIFF_W = 5;
    localparam int unsigned CNT_W  = 4;

    localparam logic [SYM_W-1:0] TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOKEN_11 = 10'b1010101011;

    logic [CNT_W-1:0]               w_n1;
    logic signed [DIFF_W-1:0]       w_diff;

    logic [QM_W-1:0]                r_qm;
    logic                           r_ve;
    logic [1:0]                     r_ctrl;
    logic signed [DIFF_W-1:0]       r_diff;

    logic [SYM_W-1:0]               r_tmds;
    logic signed [TALLY_WIDTH-1:0]  r_tally;

    logic                           w_t_zero;
    logic                           w_t_neg;
    logic                           w_d_zero;
    logic                           w_d_neg;
    logic signed [TALLY_WIDTH-1:0]  w_d_ext;
    logic signed [TALLY_WIDTH-1:0]  w_two_q8;
    logic signed [TALLY_WIDTH-1:0]  w_two_nq8;
    logic [SYM_W-1:0]               w_tmds_nxt;
    logic signed [TALLY_WIDTH-1:0]  w_tally_nxt;

    // Stage 1: count ones in the data byte; disparity n1 - n0 = 2*n1 - 8 (wraps correctly in 5 bits)
    always_comb begin
        w_n1 = '0;
        for (int i = 0; i < 8; i++) begin
            w_n1 = w_n1 + CNT_W'(qm_in[i]);
        end
    end

    assign w_diff = DIFF_W'({w_n1, 1'b0}) - DIFF_W'(8);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_qm   <= '0;
            r_ve   <= 1'b0;
            r_ctrl <= '0;
            r_diff <= '0;
        end else begin
            r_qm   <= qm_in;
            r_ve   <= ve_in;
            r_ctrl <= ctrl_in;
            r_diff <= w_diff;
        end
    end

    // Stage 2: balance decision against the current tally
    assign w_t_zero  = (r_tally == '0);
    assign w_t_neg   = r_tally[TALLY_WIDTH-1];
    assign w_d_zero  = (r_diff == '0);
    assign w_d_neg   = r_diff[DIFF_W-1];
    assign w_d_ext   = TALLY_WIDTH'(r_diff);
    assign w_two_q8  = r_qm[8] ? TALLY_WIDTH'(2) : '0;
    assign w_two_nq8 = r_qm[8] ? '0 : TALLY_WIDTH'(2);

    always_comb begin
        w_tmds_nxt  = TOKEN_00;
        w_tally_nxt = '0;
        if (!r_ve) begin
            case (r_ctrl)
                2'b00:   w_tmds_nxt = TOKEN_00;
                2'b01:   w_tmds_nxt = TOKEN_01;
                2'b10:   w_tmds_nxt = TOKEN_10;
                default: w_tmds_nxt = TOKEN_11;
            endcase
        end else if (w_t_zero || w_d_zero) begin
            w_tmds_nxt  = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_tally_nxt = r_qm[8] ? (r_tally + w_d_ext) : (r_tally - w_d_ext);
        end else if (w_t_neg == w_d_neg) begin
            // Tally and word lean the same way: invert the data byte to pull back
            w_tmds_nxt  = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_tally_nxt = r_tally + w_two_q8 - w_d_ext;
        end else begin
            w_tmds_nxt  = {1'b0, r_qm[8], r_qm[7:0]};
            w_tally_nxt = r_tally - w_two_nq8 + w_d_ext;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tmds  <= '0;
            r_tally <= '0;
        end else begin
            r_tmds  <= w_tmds_nxt;
            r_tally <= w_tally_nxt;
        end
    end

    assign tmds_out  = r_tmds;
    assign tally_out = r_tally;

endmodule

// File: tb/tb_tmds_dc_balance.sv
// Self-checking bench for tmds_dc_balance: directed cases plus random traffic against a
// reference model that derives the tally from the disparity of each emitted word.
module tb_tmds_dc_balance;

    localparam int unsigned TW = 5;

    logic                 clk_in;
    logic                 rst_in;
    logic [8:0]           qm_in;
    logic                 ve_in;
    logic [1:0]           ctrl_in;
    logic [9:0]           tmds_out;
    logic signed [TW-1:0] tally_out;

    typedef struct {
        logic [8:0] qm;
        logic       ve;
        logic [1:0] ctrl;
    } samp_t;

    samp_t pend[$];
    int    m_tally;
    int    rd;
    int    errors;
    int    checks;

    tmds_dc_balance #(.TALLY_WIDTH(TW)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .qm_in     (qm_in),
        .ve_in     (ve_in),
        .ctrl_in   (ctrl_in),
        .tmds_out  (tmds_out),
        .tally_out (tally_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic int ones(input logic [9:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(v[i]);
        return c;
    endfunction

    // Reference: pick inversion from the sign rules, then tally moves by the word's own disparity
    function automatic logic [9:0] ref_word(input samp_t s, input int t);
        logic [9:0] tok [4];
        logic [9:0] q10;
        int d;
        logic inv;
        tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
        if (!s.ve) return tok[s.ctrl];
        q10 = {2'b00, s.qm[7:0]};
        d = 2 * ones(q10, 8) - 8;
        if (t == 0 || d == 0) inv = !s.qm[8];
        else inv = ((t > 0) == (d > 0));
        return {inv, s.qm[8], inv ? ~s.qm[7:0] : s.qm[7:0]};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic chk_true(input string tag, input bit ok, input int obs);
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s observed=%0d expected within bound", tag, obs);
        end
    endtask

    task automatic step(input logic [8:0] qm, input logic ve, input logic [1:0] ctrl);
        samp_t s;
        samp_t o;
        logic [9:0] ew;
        qm_in = qm; ve_in = ve; ctrl_in = ctrl;
        s.qm = qm; s.ve = ve; s.ctrl = ctrl;
        @(posedge clk_in);
        pend.push_back(s);
        #1;
        if (pend.size() >= 2) begin
            o  = pend.pop_front();
            ew = ref_word(o, m_tally);
            m_tally = o.ve ? (m_tally + 2 * ones(ew, 10) - 10) : 0;
            chk("tmds_out", int'(tmds_out), int'(ew));
            chk("tally_out", int'(tally_out), m_tally);
            chk_true("tally_bound", int'(tally_out) <= 16 && int'(tally_out) >= -16, int'(tally_out));
            rd = o.ve ? (rd + 2 * ones(tmds_out, 10) - 10) : 0;
            chk_true("stream_disparity", rd <= 16 && rd >= -16, rd);
        end
    endtask

    task automatic apply_reset();
        samp_t z;
        rst_in = 1'b1;
        #1;
        chk("rst_async_tmds", int'(tmds_out), 0);
        chk("rst_async_tally", int'(tally_out), 0);
        pend.delete();
        m_tally = 0;
        rd = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_held_tmds", int'(tmds_out), 0);
        chk("rst_held_tally", int'(tally_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        // Stage 1 comes out of reset holding ve=0, ctrl=00
        z.qm = '0; z.ve = 1'b0; z.ctrl = 2'b00;
        pend.push_back(z);
    endtask

    initial begin
        logic [9:0] tok_exp [4];
        clk_in = 1'b0; rst_in = 1'b1; qm_in = '0; ve_in = 1'b0; ctrl_in = '0;
        errors = 0; checks = 0; m_tally = 0; rd = 0;
        tok_exp[0] = 10'h354; tok_exp[1] = 10'h0AB; tok_exp[2] = 10'h154; tok_exp[3] = 10'h2AB;

        #3;
        apply_reset();

        // Control tokens
        for (int i = 0; i < 5; i++) begin
            step(9'(i * 37), 1'b0, 2'(i));
            if (i > 0) begin
                chk("token_word", int'(tmds_out), int'(tok_exp[i-1]));
                chk("token_tally", int'(tally_out), 0);
            end
        end

        // Video from tally 0 with an all-zero XOR word
        step(9'h100, 1'b1, 2'b00);
        step(9'h100, 1'b1, 2'b00);
        chk("vid_first_word", int'(tmds_out), 'h100);
        chk("vid_first_tally", int'(tally_out), -8);
        step(9'h000, 1'b0, 2'b00);
        chk("vid_second_word", int'(tmds_out), 'h3FF);
        chk("vid_second_tally", int'(tally_out), 2);

        // Balanced data words starting from tally 0
        step(9'h10F, 1'b1, 2'b00);
        step(9'h00F, 1'b1, 2'b00);
        chk("bal_xor_word", int'(tmds_out), 'h10F);
        chk("bal_xor_tally", int'(tally_out), 0);
        step(9'h000, 1'b0, 2'b11);
        chk("bal_xnor_word", int'(tmds_out), 'h2F0);
        chk("bal_xnor_tally", int'(tally_out), 0);

        // Video/control alternating every cycle
        for (int i = 0; i < 40; i++) begin
            step(9'($urandom), 1'((i % 2) == 0), 2'($urandom));
        end

        // Asynchronous reset mid-stream with a non-zero tally in flight
        step(9'h100, 1'b1, 2'b00);
        step(9'h100, 1'b1, 2'b00);
        step(9'h0FF, 1'b1, 2'b00);
        #2;
        apply_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(9'($urandom), 1'($urandom_range(3) != 0), 2'($urandom));
            if (i == 1500) begin
                #2;
                apply_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
